// File: rtl/dmem_sram_ctrl_if.sv
// dmem_sram_ctrl_if: MEM-stage request bus plus external 16-bit SRAM bus
// for the data-memory SRAM controller.
// master = MEM stage / SRAM side (drives requests and SRAM read data),
// slave  = controller (answers requests and drives the SRAM pins).
interface dmem_sram_ctrl_if;
   // MEM-stage side
   logic        rd_en;
   logic        wr_en;
   logic [31:0] address;
   logic [31:0] write_data;
   logic [31:0] read_data;
   logic        ready;
   // SRAM side
   logic [17:0] sram_addr;
   logic [15:0] sram_dq_out;
   logic [15:0] sram_dq_in;
   logic        sram_dq_oe;
   logic        sram_we_n;

   modport master (
      output rd_en, wr_en, address, write_data, sram_dq_in,
      input  read_data, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
   );

   modport slave (
      input  rd_en, wr_en, address, write_data, sram_dq_in,
      output read_data, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
   );
endinterface

// File: rtl/dmem_sram_ctrl.sv
// dmem_sram_ctrl: turns one 32-bit MEM-stage load/store into two 16-bit
// SRAM accesses (low half, then high half), each held WAIT_CYCLES cycles.
// ready stays low while an access is in flight so the pipeline stalls.
// Optional macro SRAM_READ_CACHE_EN adds a one-entry read cache that lets a
// repeated load of the last word read complete in the request cycle.
module dmem_sram_ctrl #(
   parameter int unsigned WAIT_CYCLES = 2,         // 1..15
   parameter logic [31:0] ADDR_BASE   = 32'd1024
) (
   input  logic clk,
   input  logic rst,                               // async, active low
   dmem_sram_ctrl_if.slave bus
);

   typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

   localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

   state_t      state_q;
   logic [3:0]  cnt_q;
   logic        op_wr_q;
   logic [16:0] word_q;
   logic [31:0] wdata_q;
   logic [31:0] read_data_q;
   logic [17:0] sram_addr_q;
   logic [15:0] sram_dq_out_q;
   logic        sram_dq_oe_q;
   logic        sram_we_n_q;

   logic [31:0] offset_d;
   logic [16:0] word_d;
   logic        req;
   logic        last_cnt;
   logic        cache_hit;
   logic        unused_offset_bits;

   // Byte address -> word address within the data segment; low two bits
   // and everything above the 17-bit word index are dropped.
   assign offset_d           = bus.address - ADDR_BASE;
   assign word_d             = offset_d[18:2];
   assign unused_offset_bits = ^{offset_d[31:19], offset_d[1:0]};

   assign req      = bus.rd_en | bus.wr_en;
   assign last_cnt = (cnt_q == LAST_CNT);

`ifdef SRAM_READ_CACHE_EN
   logic        cache_valid_q;
   logic [16:0] cache_tag_q;

   // A plain read of the most recently loaded word can be answered at once,
   // read_data already holds it.
   assign cache_hit = (state_q == IDLE) && bus.rd_en && !bus.wr_en &&
                      cache_valid_q && (cache_tag_q == word_d);
`else
   assign cache_hit = 1'b0;
`endif

   // ready also covers the idle pipeline (no request) and cache hits.
   assign bus.ready = ~req | (state_q == DONE) | cache_hit;

   assign bus.read_data   = read_data_q;
   assign bus.sram_addr   = sram_addr_q;
   assign bus.sram_dq_out = sram_dq_out_q;
   assign bus.sram_dq_oe  = sram_dq_oe_q;
   assign bus.sram_we_n   = sram_we_n_q;

   // Access sequencer: all SRAM pins are registered and set up one cycle
   // ahead, on the transition into the phase that uses them.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= IDLE;
         cnt_q         <= 4'd0;
         op_wr_q       <= 1'b0;
         word_q        <= 17'd0;
         wdata_q       <= 32'd0;
         read_data_q   <= 32'd0;
         sram_addr_q   <= 18'd0;
         sram_dq_out_q <= 16'd0;
         sram_dq_oe_q  <= 1'b0;
         sram_we_n_q   <= 1'b1;
`ifdef SRAM_READ_CACHE_EN
         cache_valid_q <= 1'b0;
         cache_tag_q   <= 17'd0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (req && !cache_hit) begin
                  // Write wins when both requests are raised together.
                  state_q       <= LO;
                  cnt_q         <= 4'd0;
                  op_wr_q       <= bus.wr_en;
                  word_q        <= word_d;
                  wdata_q       <= bus.write_data;
                  sram_addr_q   <= {word_d, 1'b0};
                  sram_dq_out_q <= bus.write_data[15:0];
                  sram_dq_oe_q  <= bus.wr_en;
                  sram_we_n_q   <= ~bus.wr_en;
`ifdef SRAM_READ_CACHE_EN
                  if (bus.wr_en) begin
                     cache_valid_q <= 1'b0;
                  end
`endif
               end
            end
            LO: begin
               if (last_cnt) begin
                  state_q       <= HI;
                  cnt_q         <= 4'd0;
                  sram_addr_q   <= {word_q, 1'b1};
                  sram_dq_out_q <= wdata_q[31:16];
                  if (!op_wr_q) begin
                     read_data_q[15:0] <= bus.sram_dq_in;
                  end
               end else begin
                  cnt_q <= cnt_q + 4'd1;
               end
            end
            HI: begin
               if (last_cnt) begin
                  state_q      <= DONE;
                  cnt_q        <= 4'd0;
                  sram_dq_oe_q <= 1'b0;
                  sram_we_n_q  <= 1'b1;
                  if (!op_wr_q) begin
                     read_data_q[31:16] <= bus.sram_dq_in;
`ifdef SRAM_READ_CACHE_EN
                     cache_valid_q <= 1'b1;
                     cache_tag_q   <= word_q;
`endif
                  end
               end else begin
                  cnt_q <= cnt_q + 4'd1;
               end
            end
            DONE: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/dmem_sram_ctrl.md
Name: dmem_sram_ctrl

Overview:
- Multi-cycle controller that replaces the on-chip data memory of the MEM stage with an external 16-bit-wide SRAM.
- Accepts one 32-bit read or write from the MEM stage and sequences it as two 16-bit SRAM accesses (low half, then high half).
- Drives `ready` low while an access is in flight; the pipeline freeze logic stalls IF..MEM on `ready`=0.

Parameters:
- WAIT_CYCLES, 2, cycles each half-word access is held on the SRAM bus (legal 1..15).
- ADDR_BASE, 1024, data-segment base address subtracted from the byte address before mapping.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- rd_en  in  1  MEM-stage read request (held until ready).
- wr_en  in  1  MEM-stage write request (held until ready).
- address  in  32  byte address (ALU result).
- write_data  in  32  store data (reg2 value).
- read_data  out  32  registered load data.
- ready  out  1  access complete / no access pending.
- sram_addr  out  18  SRAM half-word address.
- sram_dq_out  out  16  SRAM write data.
- sram_dq_in  in  16  SRAM read data.
- sram_dq_oe  out  1  1 = controller drives SRAM data bus.
- sram_we_n  out  1  SRAM write enable, active low.

Behaviour:
- Reset (rst=0, async): state=IDLE, wait counter=0, read_data=0, sram_addr=0, sram_dq_out=0, sram_dq_oe=0, sram_we_n=1.
- Address map:
  - word = (address - ADDR_BASE) >> 2, unsigned 32-bit subtract, bits [16:0] kept.
  - sram_addr = {word[16:0], half}, with half=0 for the low phase and 1 for the high phase.
  - Address bits [1:0] are ignored.
- FSM states: IDLE, LO, HI, DONE.
  - IDLE: if rd_en|wr_en, latch op (wr_en has priority if both are set), word address and write_data; go to LO with counter=0.
  - LO: counter increments each cycle. On counter==WAIT_CYCLES-1 go to HI with counter=0.
  - HI: same counting; on the last cycle go to DONE.
  - DONE: one cycle, then IDLE.
- ready is combinational: ready = ~(rd_en|wr_en) | (state==DONE).
- Latency: request first seen in cycle n.
  - LO occupies n+1..n+W, HI occupies n+W+1..n+2W, DONE is n+2W+1.
  - ready=1 in cycle n+2W+1; the pipeline advances at the end of that cycle.
  - Total 2W+2 cycles (6 for W=2).
- Write:
  - During LO/HI, sram_dq_oe=1, sram_we_n=0, and sram_dq_out = latched data[15:0] in LO or [31:16] in HI.
  - In IDLE/DONE, sram_we_n=1 and sram_dq_oe=0.
- Read:
  - sram_we_n=1 and sram_dq_oe=0 throughout.
  - On the last LO cycle, read_data[15:0] <= sram_dq_in; on the last HI cycle, read_data[31:16] <= sram_dq_in.
  - read_data holds its value otherwise, including across writes.
- Request dropped mid-access: the access completes using the latched op and address; the SRAM is never left mid-write. The next request is accepted only from IDLE.
- Back-to-back requests: a request held in the cycle after DONE starts a new access (IDLE→LO) with no idle gap beyond that IDLE cycle.
- Reset asserted mid-access: immediate return to IDLE with reset values; the half-word already written is not rolled back.

Optional Feature:
- Macro SRAM_READ_CACHE_EN.
- Defined:
  - One-entry read cache: the word address of the last completed read plus a valid bit.
  - The valid bit is cleared on reset and on any write (set when the write is latched).
  - In IDLE, rd_en with a matching word address and valid=1 is a hit: ready=1 in the same cycle, the FSM stays IDLE, no SRAM cycle occurs, and read_data is unchanged (it already holds the word).
  - A miss behaves as normal.
- Undefined: no cache; every read takes 2W+2 cycles.

Test Plan:
- Reset: assert rst=0 mid-HI of a write -> next cycle state IDLE, sram_we_n=1, sram_dq_oe=0, read_data=0, ready=~(rd_en|wr_en).
- Write, W=2: address=1032, write_data=0xDEADBEEF in cycle 0 -> the SRAM model receives sram_addr=4 with 0xBEEF in cycles 1-2, then sram_addr=5 with 0xDEAD in cycles 3-4; ready=1 only in cycle 5.
- Read back, address=1032 -> read_data=0xDEADBEEF and ready=1 in cycle 5 after the request; sram_we_n=1 throughout.
- Request dropped in cycle 2 of a write to 1036 with data 0x12345678 -> both halves are still written to SRAM words 6/7; ready=1 in the cycles where rd_en=wr_en=0.
- rd_en=wr_en=1 at address 1040 with data 0xA5A5A5A5 -> a write is performed; a later read returns 0xA5A5A5A5.
- SRAM_READ_CACHE_EN: read 1032 twice -> second read has ready=1 in its first cycle with no SRAM activity; after a write to 1044, a read of 1032 takes 6 cycles again.
